// File: rtl/kronos_if_prefetch.sv
// Kronos RV32I instruction fetch with a DEPTH-entry prefetch queue feeding the IF/ID handshake.
// Define KRONOS_IF_MISALIGN_EN to turn misaligned branch targets into a fault entry plus HALT.
module kronos_if_prefetch #(
  parameter logic [31:0] PC_START = 32'h0,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         rstz,
  output logic [31:0]                  instr_addr,
  output logic                         instr_req,
  input  logic [31:0]                  instr_data,
  input  logic                         instr_gnt,
  output logic [63:0]                  fetch,  // pipeIFID_t {pc[63:32], ir[31:0]}
  output logic                         fetch_err,
  output logic                         pipe_out_vld,
  input  logic                         pipe_out_rdy,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  input  logic [31:0]                  branch_target,
  input  logic                         branch
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StInit, StRun, StHalt} state_e;

  state_e            state_q, state_d;
  logic [31:0]       pc_q;
  logic [PtrW-1:0]   head_q, tail_q;
  logic [CntW-1:0]   count_q;
  logic [63:0]       mem_q [DEPTH];
  logic              push, pop;
  logic [31:0]       target;
  logic              misalign;

`ifdef KRONOS_IF_MISALIGN_EN
  logic [DEPTH-1:0]  err_q;

  assign target   = branch_target;
  assign misalign = branch & (|branch_target[1:0]);
`else
  logic              unused_target_lsb;

  assign target            = {branch_target[31:2], 2'b00};
  assign misalign          = 1'b0;
  assign unused_target_lsb = ^branch_target[1:0];
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rstz) begin
      state_q <= StInit;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; a branch overrides every other transition
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInit:  state_d = StRun;
      StRun:   state_d = StRun;
      StHalt:  state_d = StHalt;
      default: state_d = StInit;
    endcase
    if (branch) begin
      state_d = misalign ? StHalt : StRun;
    end
  end

  // Outputs
  always_comb begin
    instr_addr   = pc_q;
    fifo_count   = count_q;
    pipe_out_vld = (count_q != '0);
    fetch        = mem_q[head_q];
    pop          = pipe_out_vld & pipe_out_rdy;
    // A pop this cycle frees the slot the push will land in, so full is not a stall
    instr_req    = (state_q == StRun) & ~branch & ((count_q < CntW'(DEPTH)) | pop);
    push         = instr_req & instr_gnt;
  end

`ifdef KRONOS_IF_MISALIGN_EN
  assign fetch_err = pipe_out_vld & err_q[head_q];
`else
  assign fetch_err = 1'b0;
`endif

  // Queue control and program counter
  always_ff @(posedge clk) begin
    if (!rstz) begin
      pc_q    <= PC_START;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (branch) begin
      pc_q   <= target;
      head_q <= '0;
      if (misalign) begin
        tail_q  <= PtrW'(1);
        count_q <= CntW'(1);
      end else begin
        tail_q  <= '0;
        count_q <= '0;
      end
    end else begin
      if (push) begin
        pc_q   <= pc_q + 32'd4;
        tail_q <= tail_q + 1'b1;
      end
      if (pop) begin
        head_q <= head_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Queue storage; contents need no reset because count gates validity
  always_ff @(posedge clk) begin
    if (branch) begin
      if (misalign) begin
        mem_q[0] <= {target, 32'h0};
      end
    end else if (push) begin
      mem_q[tail_q] <= {pc_q, instr_data};
    end
  end

`ifdef KRONOS_IF_MISALIGN_EN
  always_ff @(posedge clk) begin
    if (branch) begin
      if (misalign) begin
        err_q[0] <= 1'b1;
      end
    end else if (push) begin
      err_q[tail_q] <= 1'b0;
    end
  end
`endif

endmodule
